// File: rtl/memaccess_seq_pkg.sv
// Shared types and constants for the memaccess_seq sequencer and its wait counter.
package memaccess_seq_pkg;

    typedef enum logic [1:0] {
        K_LOAD      = 2'b00,
        K_LOAD_IND  = 2'b01,
        K_STORE     = 2'b10,
        K_STORE_IND = 2'b11
    } kind_t;

    typedef logic [1:0] mem_state_t;

    localparam mem_state_t MS_READ     = 2'b00;
    localparam mem_state_t MS_IND_READ = 2'b01;
    localparam mem_state_t MS_WRITE    = 2'b10;
    localparam mem_state_t MS_IDLE     = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IND,
        S_RD,
        S_WR,
        S_RESP
    } state_t;

    localparam logic [15:0] IO_BASE = 16'hFE00;

    function automatic logic is_indirect(input kind_t kind);
        return (kind == K_LOAD_IND) || (kind == K_STORE_IND);
    endfunction

endpackage

// File: rtl/memaccess_seq_wait.sv
// Read-latency wait counter: restarts from zero on each state entry and
// flags done once RD_LATENCY extra cycles have elapsed in a read state.
module memaccess_seq_wait #(
    parameter int RD_LATENCY = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic run,
    output logic done
);

    localparam int CNT_W = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(RD_LATENCY);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (run && (count != LAST)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign done = (count == LAST);

endmodule

// File: rtl/memaccess_seq.sv
// Memory-access sequencer feeding the LC3 MemAccess stage (direct and indirect loads/stores).
// Optional io_hit output is enabled with `define MEMACCESS_SEQ_IO_CHK_EN.
module memaccess_seq
    import memaccess_seq_pkg::*;
#(
    parameter int RD_LATENCY = 0,
    parameter int ADDR_W     = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  kind_t             req_kind,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [ADDR_W-1:0] req_data,
    output logic [1:0]        mem_state,
    output logic [ADDR_W-1:0] M_Addr,
    output logic [ADDR_W-1:0] M_Data,
    output logic              M_Control,
    input  logic [ADDR_W-1:0] DMem_dout,
    output logic              rsp_valid,
    output logic [ADDR_W-1:0] rsp_data
`ifdef MEMACCESS_SEQ_IO_CHK_EN
    ,
    output logic              io_hit
`endif
);

    state_t            state;
    state_t            state_nxt;
    kind_t             kind_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] data_q;
    logic [ADDR_W-1:0] ind_addr;

    logic              accept;
    logic              wait_start;
    logic              wait_run;
    logic              wait_done;

    // Request fields as they will be after this edge (captured on accept)
    kind_t             kind_n;
    logic [ADDR_W-1:0] addr_n;
    logic [ADDR_W-1:0] data_n;
    logic [ADDR_W-1:0] ind_n;
    logic [ADDR_W-1:0] final_addr_n;
    logic              indirect_n;

    mem_state_t        mem_state_n;
    logic [ADDR_W-1:0] m_addr_n;
    logic [ADDR_W-1:0] m_data_n;
    logic [ADDR_W-1:0] rsp_data_n;
    logic              m_control_n;
    logic              rsp_valid_n;
    logic              req_ready_n;

    assign accept     = req_valid && req_ready;
    assign wait_start = (state_nxt != state);
    assign wait_run   = (state == S_IND) || (state == S_RD);

    memaccess_seq_wait #(
        .RD_LATENCY(RD_LATENCY)
    ) u_wait (
        .clock(clock),
        .reset(reset),
        .start(wait_start),
        .run  (wait_run),
        .done (wait_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (req_kind)
                        K_LOAD:  state_nxt = S_RD;
                        K_STORE: state_nxt = S_WR;
                        default: state_nxt = S_IND;
                    endcase
                end
            end
            S_IND: begin
                if (wait_done) begin
                    state_nxt = (kind_q == K_LOAD_IND) ? S_RD : S_WR;
                end
            end
            S_RD: begin
                if (wait_done) begin
                    state_nxt = S_RESP;
                end
            end
            S_WR:    state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            kind_q <= req_kind;
            addr_q <= req_addr;
            data_q <= req_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ind_addr <= '0;
        end else begin
            ind_addr <= ind_n;
        end
    end

    always_comb begin
        kind_n       = accept ? req_kind : kind_q;
        addr_n       = accept ? req_addr : addr_q;
        data_n       = accept ? req_data : data_q;
        // A zero pointer is a valid address and is used unchanged
        ind_n        = ((state == S_IND) && wait_done) ? DMem_dout : ind_addr;
        indirect_n   = is_indirect(kind_n);
        final_addr_n = indirect_n ? ind_n : addr_n;
    end

    // Outputs are decoded from the state being entered so they register with it
    always_comb begin
        mem_state_n = MS_IDLE;
        m_addr_n    = M_Addr;
        m_data_n    = M_Data;
        m_control_n = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data;
        req_ready_n = 1'b0;
        case (state_nxt)
            S_IDLE: begin
                req_ready_n = 1'b1;
            end
            S_IND: begin
                mem_state_n = MS_IND_READ;
                m_addr_n    = addr_n;
            end
            S_RD: begin
                mem_state_n = MS_READ;
                m_addr_n    = final_addr_n;
                m_control_n = indirect_n;
            end
            S_WR: begin
                mem_state_n = MS_WRITE;
                m_addr_n    = final_addr_n;
                m_data_n    = data_n;
                m_control_n = indirect_n;
            end
            S_RESP: begin
                rsp_valid_n = 1'b1;
                rsp_data_n  = (state == S_RD) ? DMem_dout : '0;
            end
            default: begin
                mem_state_n = MS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_state <= MS_IDLE;
            M_Addr    <= '0;
            M_Data    <= '0;
            M_Control <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            req_ready <= 1'b1;
        end else begin
            mem_state <= mem_state_n;
            M_Addr    <= m_addr_n;
            M_Data    <= m_data_n;
            M_Control <= m_control_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            req_ready <= req_ready_n;
        end
    end

`ifdef MEMACCESS_SEQ_IO_CHK_EN
    localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);

    logic io_hit_n;

    assign io_hit_n = (state_nxt == S_RESP) && (final_addr_n >= IO_BASE_A);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_hit <= 1'b0;
        end else begin
            io_hit <= io_hit_n;
        end
    end
`endif

endmodule

// File: tb/tb_memaccess_seq.sv
// Self-checking bench for memaccess_seq: one instance with RD_LATENCY=0, one with RD_LATENCY=2.
`timescale 1ns/1ps
module tb_memaccess_seq;
    import memaccess_seq_pkg::*;

    localparam int TMO = 40;

    typedef struct {
        logic [15:0] data;
        int          lat;
        logic        io;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset;

    logic        v0, rdy0, mc0, rv0;
    kind_t       k0;
    logic [15:0] a0, d0, dout0, ma0, md0, rd0;
    logic [1:0]  ms0;

    logic        v2, rdy2, mc2, rv2;
    kind_t       k2;
    logic [15:0] a2, d2, dout2, ma2, md2, rd2;
    logic [1:0]  ms2;

`ifdef MEMACCESS_SEQ_IO_CHK_EN
    logic io0, io2;
`endif

    int errors = 0;
    int checks = 0;
    exp_t sb0[$];
    exp_t sb2[$];

    memaccess_seq #(.RD_LATENCY(0), .ADDR_W(16)) u_dut0 (
        .clock(clock), .reset(reset),
        .req_valid(v0), .req_ready(rdy0), .req_kind(k0), .req_addr(a0), .req_data(d0),
        .mem_state(ms0), .M_Addr(ma0), .M_Data(md0), .M_Control(mc0),
        .DMem_dout(dout0), .rsp_valid(rv0), .rsp_data(rd0)
`ifdef MEMACCESS_SEQ_IO_CHK_EN
        , .io_hit(io0)
`endif
    );

    memaccess_seq #(.RD_LATENCY(2), .ADDR_W(16)) u_dut2 (
        .clock(clock), .reset(reset),
        .req_valid(v2), .req_ready(rdy2), .req_kind(k2), .req_addr(a2), .req_data(d2),
        .mem_state(ms2), .M_Addr(ma2), .M_Data(md2), .M_Control(mc2),
        .DMem_dout(dout2), .rsp_valid(rv2), .rsp_data(rd2)
`ifdef MEMACCESS_SEQ_IO_CHK_EN
        , .io_hit(io2)
`endif
    );

    // Small combinational data memory shared by both instances
    function automatic logic [15:0] mem_model(input logic [15:0] addr);
        case (addr)
            16'h3010: return 16'hBEEF;
            16'h3020: return 16'h4000;
            16'h3000: return 16'h3100;
            16'h3100: return 16'h00AA;
            16'h3030: return 16'h0000;
            default:  return addr ^ 16'h5A5A;
        endcase
    endfunction

    assign dout0 = mem_model(ma0);
    assign dout2 = mem_model(ma2);

    task automatic issue0(input kind_t k, input logic [15:0] a, input logic [15:0] d, output logic ok);
        int n;
        n = 0;
        @(negedge clock);
        k0 = k; a0 = a; d0 = d; v0 = 1'b1;
        while (rdy0 !== 1'b1 && n < TMO) begin
            @(negedge clock);
            n++;
        end
        ok = (rdy0 === 1'b1);
        @(posedge clock);
        #1;
        v0 = 1'b0; k0 = K_STORE_IND; a0 = ~a; d0 = ~d;
    endtask

    task automatic issue2(input kind_t k, input logic [15:0] a, input logic [15:0] d, output logic ok);
        int n;
        n = 0;
        @(negedge clock);
        k2 = k; a2 = a; d2 = d; v2 = 1'b1;
        while (rdy2 !== 1'b1 && n < TMO) begin
            @(negedge clock);
            n++;
        end
        ok = (rdy2 === 1'b1);
        @(posedge clock);
        #1;
        v2 = 1'b0; k2 = K_STORE_IND; a2 = ~a; d2 = ~d;
    endtask

    task automatic wait_rsp0(inout int lat);
        while (rv0 !== 1'b1 && lat < TMO) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic wait_rsp2(inout int lat);
        while (rv2 !== 1'b1 && lat < TMO) begin
            @(negedge clock);
            lat++;
        end
    endtask

    task automatic test_reset;
        logic bad;
        reset = 1'b1;
        v0 = 1'b0; k0 = K_LOAD; a0 = '0; d0 = '0;
        v2 = 1'b0; k2 = K_LOAD; a2 = '0; d2 = '0;
        repeat (3) @(negedge clock);
        checks++;
        if ({ms0, rdy0, rv0, mc0, ma0, md0, rd0} !== {2'b11, 1'b1, 1'b0, 1'b0, 48'h0}) begin
            errors++;
            $display("FAIL reset_values0: ms=%b rdy=%b rv=%b mc=%b ma=%h md=%h rd=%h, want 11 1 0 0 0 0 0",
                     ms0, rdy0, rv0, mc0, ma0, md0, rd0);
        end
`ifdef MEMACCESS_SEQ_IO_CHK_EN
        checks++;
        if ({io0, io2} !== 2'b00) begin
            errors++;
            $display("FAIL reset_io_hit: got %b%b want 00", io0, io2);
        end
`endif
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            bad = ({ms0, rdy0, rv0} !== {2'b11, 1'b1, 1'b0}) || ({ms2, rdy2, rv2} !== {2'b11, 1'b1, 1'b0});
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL idle_cycle%0d: dut0 ms=%b rdy=%b rv=%b dut2 ms=%b rdy=%b rv=%b, want 11 1 0",
                         i, ms0, rdy0, rv0, ms2, rdy2, rv2);
            end
        end
    endtask

    task automatic test_load;
        exp_t e;
        logic ok;
        int   lat;
        e.data = mem_model(16'h3010); e.lat = 2; e.io = 1'b0;
        sb0.push_back(e);
        issue0(K_LOAD, 16'h3010, 16'h7777, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL load_accept: req_ready=%b want 1", rdy0); end
        @(negedge clock);
        lat = 1;
        checks++;
        if ({ms0, ma0, mc0, rv0} !== {MS_READ, 16'h3010, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL load_rd_phase: ms=%b ma=%h mc=%b rv=%b, want 00 3010 0 0", ms0, ma0, mc0, rv0);
        end
        wait_rsp0(lat);
        checks++;
        if (rv0 !== 1'b1) begin
            errors++; $display("FAIL load_timeout: no rsp_valid within %0d cycles", TMO); sb0.delete();
        end else begin
            e = sb0.pop_front();
            if (lat !== e.lat || rd0 !== e.data) begin
                errors++;
                $display("FAIL load_rsp: lat=%0d data=%h, want lat=%0d data=%h", lat, rd0, e.lat, e.data);
            end
        end
        @(negedge clock);
        checks++;
        if ({rv0, rdy0, ms0} !== {1'b0, 1'b1, MS_IDLE}) begin
            errors++;
            $display("FAIL load_after_rsp: rv=%b rdy=%b ms=%b, want 0 1 11", rv0, rdy0, ms0);
        end
    endtask

    task automatic test_store;
        exp_t e;
        logic ok;
        int   lat;
        e.data = 16'h0000; e.lat = 2; e.io = 1'b0;
        sb0.push_back(e);
        issue0(K_STORE, 16'h3040, 16'h5555, ok);
        @(negedge clock);
        lat = 1;
        checks++;
        if ({ok, ms0, ma0, md0, mc0} !== {1'b1, MS_WRITE, 16'h3040, 16'h5555, 1'b0}) begin
            errors++;
            $display("FAIL store_wr_phase: ok=%b ms=%b ma=%h md=%h mc=%b, want 1 10 3040 5555 0",
                     ok, ms0, ma0, md0, mc0);
        end
        wait_rsp0(lat);
        checks++;
        if (rv0 !== 1'b1) begin
            errors++; $display("FAIL store_timeout: no rsp_valid within %0d cycles", TMO); sb0.delete();
        end else begin
            e = sb0.pop_front();
            if (lat !== e.lat || rd0 !== e.data) begin
                errors++;
                $display("FAIL store_rsp: lat=%0d data=%h, want lat=%0d data=%h", lat, rd0, e.lat, e.data);
            end
        end
    endtask

    task automatic test_store_ind;
        exp_t e;
        logic ok;
        int   lat;
        e.data = 16'h0000; e.lat = 3; e.io = 1'b0;
        sb0.push_back(e);
        issue0(K_STORE_IND, 16'h3020, 16'h1234, ok);
        @(negedge clock);
        lat = 1;
        checks++;
        if ({ok, ms0, ma0, mc0} !== {1'b1, MS_IND_READ, 16'h3020, 1'b0}) begin
            errors++;
            $display("FAIL sti_ind_phase: ok=%b ms=%b ma=%h mc=%b, want 1 01 3020 0", ok, ms0, ma0, mc0);
        end
        @(negedge clock);
        lat = 2;
        checks++;
        if ({ms0, ma0, mc0, md0} !== {MS_WRITE, 16'h4000, 1'b1, 16'h1234}) begin
            errors++;
            $display("FAIL sti_wr_phase: ms=%b ma=%h mc=%b md=%h, want 10 4000 1 1234", ms0, ma0, mc0, md0);
        end
        wait_rsp0(lat);
        checks++;
        if (rv0 !== 1'b1) begin
            errors++; $display("FAIL sti_timeout: no rsp_valid within %0d cycles", TMO); sb0.delete();
        end else begin
            e = sb0.pop_front();
            if (lat !== e.lat || rd0 !== e.data) begin
                errors++;
                $display("FAIL sti_rsp: lat=%0d data=%h, want lat=%0d data=%h", lat, rd0, e.lat, e.data);
            end
        end
    endtask

    task automatic test_load_ind_zero_ptr;
        exp_t e;
        logic ok;
        int   lat;
        e.data = mem_model(16'h0000); e.lat = 3; e.io = 1'b0;
        sb0.push_back(e);
        issue0(K_LOAD_IND, 16'h3030, 16'h0000, ok);
        @(negedge clock);
        @(negedge clock);
        lat = 2;
        checks++;
        if ({ok, ms0, ma0, mc0} !== {1'b1, MS_READ, 16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL ldi_zero_rd_phase: ok=%b ms=%b ma=%h mc=%b, want 1 00 0000 1", ok, ms0, ma0, mc0);
        end
        wait_rsp0(lat);
        checks++;
        if (rv0 !== 1'b1) begin
            errors++; $display("FAIL ldi_zero_timeout: no rsp_valid within %0d cycles", TMO); sb0.delete();
        end else begin
            e = sb0.pop_front();
            if (lat !== e.lat || rd0 !== e.data || mc0 !== 1'b0) begin
                errors++;
                $display("FAIL ldi_zero_rsp: lat=%0d data=%h mc=%b, want lat=%0d data=%h mc=0",
                         lat, rd0, mc0, e.lat, e.data);
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   lat;
        int   n;
        e.data = mem_model(16'h3010); e.lat = 2; e.io = 1'b0;
        sb0.push_back(e);
        e.data = 16'h0000; e.lat = 2; e.io = 1'b0;
        sb0.push_back(e);
        @(negedge clock);
        k0 = K_LOAD; a0 = 16'h3010; d0 = 16'h0000; v0 = 1'b1;
        n = 0;
        while (rdy0 !== 1'b1 && n < TMO) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        // Second request held valid while the first is in flight
        k0 = K_STORE; a0 = 16'h3050; d0 = 16'hA5A5;
        lat = 0;
        wait_rsp0(lat);
        checks++;
        if (rv0 !== 1'b1) begin
            errors++; $display("FAIL b2b_first_timeout: no rsp_valid within %0d cycles", TMO); sb0.delete();
        end else begin
            e = sb0.pop_front();
            if (lat !== e.lat || rd0 !== e.data) begin
                errors++;
                $display("FAIL b2b_first_rsp: lat=%0d data=%h, want lat=%0d data=%h", lat, rd0, e.lat, e.data);
            end
        end
        @(negedge clock);
        lat = 1;
        checks++;
        if ({rdy0, ms0, rv0} !== {1'b1, MS_IDLE, 1'b0}) begin
            errors++;
            $display("FAIL b2b_idle_gap: rdy=%b ms=%b rv=%b, want 1 11 0", rdy0, ms0, rv0);
        end
        @(posedge clock);
        #1;
        v0 = 1'b0; a0 = 16'hFFFF; d0 = 16'hFFFF;
        wait_rsp0(lat);
        checks++;
        if (rv0 !== 1'b1 || sb0.size() == 0) begin
            errors++; $display("FAIL b2b_second_timeout: no rsp_valid within %0d cycles", TMO); sb0.delete();
        end else begin
            e = sb0.pop_front();
            if (lat !== 1 + e.lat || rd0 !== e.data || md0 !== 16'hA5A5) begin
                errors++;
                $display("FAIL b2b_second_rsp: gap=%0d data=%h md=%h, want gap=%0d data=%h md=a5a5",
                         lat, rd0, md0, 1 + e.lat, e.data);
            end
        end
    endtask

    task automatic test_lat2_kinds;
        kind_t       kinds [4];
        logic [15:0] addrs [4];
        exp_t        e;
        logic        ok;
        int          lat;
        kinds[0] = K_LOAD;      addrs[0] = 16'h3010;
        kinds[1] = K_STORE;     addrs[1] = 16'h3040;
        kinds[2] = K_STORE_IND; addrs[2] = 16'h3020;
        kinds[3] = K_LOAD;      addrs[3] = 16'h3100;
        for (int i = 0; i < 4; i++) begin
            case (kinds[i])
                K_LOAD:      begin e.lat = 2 + 2;     e.data = mem_model(addrs[i]); end
                K_STORE:     begin e.lat = 2;         e.data = 16'h0000; end
                K_STORE_IND: begin e.lat = 3 + 2;     e.data = 16'h0000; end
                default:     begin e.lat = 3 + 2 * 2; e.data = mem_model(mem_model(addrs[i])); end
            endcase
            e.io = 1'b0;
            sb2.push_back(e);
            issue2(kinds[i], addrs[i], 16'h0F0F, ok);
            lat = 0;
            wait_rsp2(lat);
            checks++;
            if (rv2 !== 1'b1) begin
                errors++; $display("FAIL lat2_kind%0d_timeout: no rsp_valid within %0d cycles", i, TMO); sb2.delete();
            end else begin
                e = sb2.pop_front();
                if (!ok || lat !== e.lat || rd2 !== e.data) begin
                    errors++;
                    $display("FAIL lat2_kind%0d_rsp: ok=%b lat=%0d data=%h, want lat=%0d data=%h",
                             i, ok, lat, rd2, e.lat, e.data);
                end
            end
        end
    endtask

    task automatic test_load_ind_lat2;
        exp_t        e;
        logic        ok;
        int          lat;
        logic [1:0]  exp_ms;
        logic [15:0] exp_ma;
        logic        exp_mc;
        e.data = 16'h00AA; e.lat = 7; e.io = 1'b0;
        sb2.push_back(e);
        issue2(K_LOAD_IND, 16'h3000, 16'h0000, ok);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clock);
            exp_ms = (i <= 3) ? MS_IND_READ : MS_READ;
            exp_ma = (i <= 3) ? 16'h3000 : 16'h3100;
            exp_mc = (i > 3);
            checks++;
            if ({ms2, ma2, mc2, rv2} !== {exp_ms, exp_ma, exp_mc, 1'b0}) begin
                errors++;
                $display("FAIL ldi_lat2_cycle%0d: ms=%b ma=%h mc=%b rv=%b, want %b %h %b 0",
                         i, ms2, ma2, mc2, rv2, exp_ms, exp_ma, exp_mc);
            end
        end
        lat = 6;
        wait_rsp2(lat);
        checks++;
        if (rv2 !== 1'b1) begin
            errors++; $display("FAIL ldi_lat2_timeout: no rsp_valid within %0d cycles", TMO); sb2.delete();
        end else begin
            e = sb2.pop_front();
            if (!ok || lat !== e.lat || rd2 !== e.data) begin
                errors++;
                $display("FAIL ldi_lat2_rsp: ok=%b lat=%0d data=%h, want lat=%0d data=%h",
                         ok, lat, rd2, e.lat, e.data);
            end
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        logic ok;
        logic seen;
        int   lat;
        e.data = mem_model(16'h3010); e.lat = 2; e.io = 1'b0;
        sb0.push_back(e);
        issue0(K_LOAD, 16'h3010, 16'h0000, ok);
        @(negedge clock);
        reset = 1'b1;
        #1;
        // The in-flight load is dropped
        sb0.delete();
        checks++;
        if ({ms0, rdy0, rv0, mc0, ma0, md0, rd0} !== {2'b11, 1'b1, 1'b0, 1'b0, 48'h0}) begin
            errors++;
            $display("FAIL reset_mid_values: ms=%b rdy=%b rv=%b mc=%b ma=%h md=%h rd=%h, want 11 1 0 0 0 0 0",
                     ms0, rdy0, rv0, mc0, ma0, md0, rd0);
        end
        seen = 1'b0;
        repeat (2) begin
            @(negedge clock);
            if (rv0 !== 1'b0) seen = 1'b1;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (rv0 !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL reset_mid_no_rsp: rsp_valid seen=%b want 0", seen);
        end
        e.data = mem_model(16'h3100); e.lat = 2; e.io = 1'b0;
        sb0.push_back(e);
        issue0(K_LOAD, 16'h3100, 16'h0000, ok);
        lat = 0;
        wait_rsp0(lat);
        checks++;
        if (rv0 !== 1'b1) begin
            errors++; $display("FAIL reset_mid_reload_timeout: no rsp_valid within %0d cycles", TMO); sb0.delete();
        end else begin
            e = sb0.pop_front();
            if (!ok || lat !== e.lat || rd0 !== e.data) begin
                errors++;
                $display("FAIL reset_mid_reload_rsp: ok=%b lat=%0d data=%h, want lat=%0d data=%h",
                         ok, lat, rd0, e.lat, e.data);
            end
        end
    endtask

`ifdef MEMACCESS_SEQ_IO_CHK_EN
    task automatic test_io;
        logic [15:0] addrs [2];
        exp_t        e;
        logic        ok;
        int          lat;
        addrs[0] = 16'hFE04;
        addrs[1] = 16'hFDFF;
        for (int i = 0; i < 2; i++) begin
            e.data = mem_model(addrs[i]); e.lat = 2; e.io = (addrs[i] >= 16'hFE00);
            sb0.push_back(e);
            issue0(K_LOAD, addrs[i], 16'h0000, ok);
            lat = 0;
            wait_rsp0(lat);
            checks++;
            if (rv0 !== 1'b1) begin
                errors++; $display("FAIL io%0d_timeout: no rsp_valid within %0d cycles", i, TMO); sb0.delete();
            end else begin
                e = sb0.pop_front();
                if (!ok || io0 !== e.io || rd0 !== e.data || lat !== e.lat) begin
                    errors++;
                    $display("FAIL io%0d_rsp: io_hit=%b data=%h lat=%0d, want io_hit=%b data=%h lat=%0d",
                             i, io0, rd0, lat, e.io, e.data, e.lat);
                end
            end
            @(negedge clock);
            checks++;
            if (io0 !== 1'b0) begin
                errors++; $display("FAIL io%0d_clear: io_hit=%b want 0", i, io0);
            end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_store();
        test_store_ind();
        test_load_ind_zero_ptr();
        test_back_to_back();
        test_lat2_kinds();
        test_load_ind_lat2();
        test_reset_mid();
`ifdef MEMACCESS_SEQ_IO_CHK_EN
        test_io();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
